mac_pe: RTL and testbench
=========================

# mac_pe

Parametrised signed multiply-accumulate processing element, the next-generation systolic-array cell for MiniTPU. It supports configurable operand/accumulator widths and a per-beat valid with first/last framing. It also offers optional saturating accumulation and a runtime-selectable weight-stationary mode with partial-sum chaining. Instances tile into the systolic array: operands flow right/down through registered forwarding ports, and results leave through a registered result port or the psum chain.

## Interface
- DATA_W, 8, operand width (signed two's complement)
- ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W
- SATURATE, 1, 1 = clamp accumulator to ACC_W signed range, 0 = wrap
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  a/b/psum_in beat valid
- a  input  DATA_W  activation operand
- b  input  DATA_W  weight operand (output-stationary), weight load data (weight-stationary)
- first  input  1  beat starts a new accumulation (qualified by in_valid)
- last  input  1  beat ends accumulation; capture result (qualified by in_valid)
- ws_mode  input  1  0 = output-stationary, 1 = weight-stationary; change only while idle
- w_load  input  1  load b into weight register (independent of in_valid)
- psum_in  input  ACC_W  partial sum from upstream PE (weight-stationary)
- a_out, b_out  output  DATA_W  registered forwards of a, b
- out_valid  output  1  registered in_valid
- result  output  ACC_W  captured accumulation
- result_valid  output  1  one-cycle pulse when result updates
- overflow  output  1  sticky saturation/wrap flag for current accumulation
- psum_out  output  ACC_W  psum_in + a*weight, registered

## Operation
- product = signed(a) * signed(b or weight), 2*DATA_W bits, sign-extended to ACC_W+1 for addition.
- Output-stationary FSM: IDLE, ACC.
  - IDLE + in_valid: acc ← product; go to ACC, or stay IDLE if last. first is implied.
  - ACC + in_valid & first: discard acc, acc ← product (restart).
  - ACC + in_valid & !first: acc ← sat(acc + product).
  - in_valid & last: result ← new acc value; result_valid pulses; FSM → IDLE.
  - first & last on the same beat: single-product result.
  - !in_valid: acc, FSM, overflow hold.
- Saturation: the sum is computed at ACC_W+1 bits. Out of range with SATURATE=1 clamps to ±max; SATURATE=0 wraps. Either case sets overflow. overflow clears on a first beat or on entry from IDLE.
- Weight-stationary: w_load → weight ← b. When in_valid, psum_out ← sat(psum_in + a*weight); otherwise psum_out holds. The accumulator FSM is unused and stays IDLE; result holds.
- a_out/b_out/out_valid forward every cycle regardless of mode or in_valid.

## Timing
- Reset (rst=0 at edge): a_out, b_out, out_valid, result, result_valid, overflow, psum_out, acc and weight all become 0; FSM → IDLE. Reset takes priority over every other input, mid-accumulation included.
- Forwarding latency: 1 cycle.
- result/result_valid: visible the cycle after the edge sampling the last beat. result_valid is high for exactly one cycle. result holds until the next last beat.
- psum_out: 1 cycle after the sampling edge.
- w_load and in_valid on the same edge in WS mode: the product uses the old weight. The new weight applies from the next beat.
- Back-to-back frames, with last followed immediately by a new beat, run without a bubble.

## Structure
- Shared package minitpu_pkg holds:
  - DATA_W/ACC_W defaults
  - the pe_state_e enum (IDLE, ACC)
  - a sat_clip function parametrised by width
- One sub-module, sat_add: ACC_W+1-bit add with a SATURATE-controlled clamp and an overflow flag. It is instantiated twice, once for the accumulator path and once for the psum path.

## Test plan
- OS, one beat (10, 20, first, last) → next cycle result=200, result_valid=1 for one cycle, overflow=0.
- OS, beats (-10,20,first), (-5,-4), (3,3), (2,3,last), with two idle cycles inserted between beats → result=-165. acc is unchanged during gaps. a_out/b_out/out_valid lag the inputs by 1 cycle.
- SATURATE=1, ACC_W=16: three beats of 127*127 → result=32767, overflow=1. Next frame of three beats of -128*127 → result=-32768. SATURATE=0, same stimulus → wrapped value, overflow=1.
- Restart: first mid-frame after accumulating 50, then beat (4,5,last) → result=20.
- WS: w_load with b=-3. Then a=7, psum_in=100, in_valid → psum_out=79 next cycle. Simultaneous w_load b=2 with a=1, psum_in=0 → psum_out=-3.
- rst=0 for one cycle mid-frame → all outputs 0 at the next edge. Following beat (6,7,last) → result=42, with no residue from the prior frame.

Source files
------------

// File: rtl/mac_pe_pkg.sv
// Shared MiniTPU definitions for the mac_pe systolic cell:
// width defaults, accumulator FSM states, clamp helper.
package minitpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_e;

  // Signed min (neg=1) or max (neg=0) of a w-bit field, low w bits valid
  function automatic logic [63:0] sat_clip(
    input logic neg,
    input int   w
  );
    logic [63:0] m;
    m = 64'd1 << (w - 1);
    return neg ? m : m - 64'd1;
  endfunction

endpackage

// File: rtl/mac_pe_if.sv
// Beat, weight-load, psum and result bundle of one mac_pe.
// master drives operands, slave is the PE.
interface mac_pe_if
  import minitpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  logic                     in_valid;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     first;
  logic                     last;
  logic                     ws_mode;
  logic                     w_load;
  logic signed [ACC_W-1:0]  psum_in;
  logic signed [DATA_W-1:0] a_out;
  logic signed [DATA_W-1:0] b_out;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  result;
  logic                     result_valid;
  logic                     overflow;
  logic signed [ACC_W-1:0]  psum_out;

  modport master (
    output in_valid, a, b, first, last,
    output ws_mode, w_load, psum_in,
    input  a_out, b_out, out_valid,
    input  result, result_valid, overflow,
    input  psum_out
  );

  modport slave (
    input  in_valid, a, b, first, last,
    input  ws_mode, w_load, psum_in,
    output a_out, b_out, out_valid,
    output result, result_valid, overflow,
    output psum_out
  );

endinterface

// File: rtl/mac_pe_sat_add.sv
// W+1-bit signed add with optional clamp to the W-bit range;
// ovf flags any out-of-range sum, clamped or wrapped.
module sat_add
  import minitpu_pkg::*;
#(
  parameter int W   = ACC_W_DEF,
  parameter bit SAT = 1'b1
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W:0] wide;

  assign wide = {x[W-1], x} + {y[W-1], y};
  assign ovf  = wide[W] ^ wide[W-1];
  assign sum  = (SAT && ovf) ? W'(sat_clip(wide[W], W))
                             : W'(wide);

endmodule

// File: rtl/mac_pe.sv
// Signed MAC systolic cell: output-stationary accumulate with
// first/last framing, or weight-stationary psum chaining.
module mac_pe
  import minitpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input logic   clk,
  input logic   rst,
  mac_pe_if.slave io
);

  pe_state_e state, state_nx;

  logic signed [DATA_W-1:0]   weight;
  logic signed [DATA_W-1:0]   op;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    psum_sum;
  logic                       acc_ovf;
  logic                       os_beat;
  logic                       restart;

  assign op       = io.ws_mode ? weight : io.b;
  assign prod     = (2*DATA_W)'(io.a) * (2*DATA_W)'(op);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (os_beat) state_nx = io.last ? IDLE : ACC;
  end

  // A beat out of IDLE or flagged first starts from zero
  always_comb begin
    os_beat  = !io.ws_mode && io.in_valid;
    restart  = (state == IDLE) || io.first;
    acc_base = restart ? '0 : acc;
  end

  sat_add #(.W(ACC_W), .SAT(SATURATE)) u_acc_add (
    .x   (acc_base),
    .y   (prod_ext),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  sat_add #(.W(ACC_W), .SAT(SATURATE)) u_psum_add (
    .x   (io.psum_in),
    .y   (prod_ext),
    .sum (psum_sum),
    .ovf ()
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      io.a_out        <= '0;
      io.b_out        <= '0;
      io.out_valid    <= 1'b0;
      io.result       <= '0;
      io.result_valid <= 1'b0;
      io.overflow     <= 1'b0;
      io.psum_out     <= '0;
      acc             <= '0;
      weight          <= '0;
    end else begin
      io.a_out        <= io.a;
      io.b_out        <= io.b;
      io.out_valid    <= io.in_valid;
      io.result_valid <= os_beat && io.last;
      if (os_beat) begin
        acc         <= acc_sum;
        io.overflow <= restart ? acc_ovf
                               : (io.overflow | acc_ovf);
        if (io.last) io.result <= acc_sum;
      end
      if (io.w_load) weight <= io.b;
      if (io.ws_mode && io.in_valid) io.psum_out <= psum_sum;
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: directed frames plus random frames against
// a reference fold over products, at ACC_W 32 and 16 sat/wrap.
module tb_mac_pe;
  import minitpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_pe_if #(.DATA_W(8), .ACC_W(32)) i32 ();
  mac_pe_if #(.DATA_W(8), .ACC_W(16)) i16s ();
  mac_pe_if #(.DATA_W(8), .ACC_W(16)) i16w ();

  mac_pe #(.DATA_W(8), .ACC_W(32), .SATURATE(1'b1)) u_32 (
    .clk (clk), .rst (rst), .io (i32)
  );
  mac_pe #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b1)) u_16s (
    .clk (clk), .rst (rst), .io (i16s)
  );
  mac_pe #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b0)) u_16w (
    .clk (clk), .rst (rst), .io (i16w)
  );

  int checks = 0;
  int errs   = 0;

  logic signed [7:0] ra, rb;
  longint q[$];
  longint e32, e16s, e16w;
  bit     o32, o16s, o16w;
  int     n;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v,
                       input logic signed [7:0] a,
                       input logic signed [7:0] b,
                       input bit f, input bit l,
                       input bit ws, input bit wl,
                       input logic signed [31:0] ps);
    i32.in_valid  = v;  i16s.in_valid = v;  i16w.in_valid = v;
    i32.a         = a;  i16s.a        = a;  i16w.a        = a;
    i32.b         = b;  i16s.b        = b;  i16w.b        = b;
    i32.first     = f;  i16s.first    = f;  i16w.first    = f;
    i32.last      = l;  i16s.last     = l;  i16w.last     = l;
    i32.ws_mode   = ws; i16s.ws_mode  = ws; i16w.ws_mode  = ws;
    i32.w_load    = wl; i16s.w_load   = wl; i16w.w_load   = wl;
    i32.psum_in   = ps;
    i16s.psum_in  = ps[15:0];
    i16w.psum_in  = ps[15:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < cyc; i++) step();
  endtask

  task automatic beat(input logic signed [7:0] a,
                      input logic signed [7:0] b,
                      input bit f, input bit l);
    drive(1, a, b, f, l, 0, 0, 0);
    step();
  endtask

  // Accumulate products the way a w-bit register would hold them
  function automatic longint fold(input longint p[$],
                                  input int w, input bit sat,
                                  output bit ovf);
    longint acc, s, hi, lo;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -hi - 1;
    acc = 0;
    ovf = 0;
    foreach (p[i]) begin
      s = acc + p[i];
      if (s > hi || s < lo) begin
        ovf = 1;
        if (sat) s = (s > hi) ? hi : lo;
        else     s = (s > hi) ? s - 2 * (hi + 1) : s + 2 * (hi + 1);
      end
      acc = s;
    end
    return acc;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("rst_result", i32.result, 0);
    chk("rst_rv", i32.result_valid, 0);
    chk("rst_ovf", i32.overflow, 0);
    chk("rst_psum", i32.psum_out, 0);
    chk("rst_aout", i32.a_out, 0);
    chk("rst_ovalid", i32.out_valid, 0);
    rst = 1'b1;
    idle(1);

    beat(10, 20, 1, 1);
    chk("one_result", i32.result, 200);
    chk("one_rv", i32.result_valid, 1);
    chk("one_ovf", i32.overflow, 0);
    idle(1);
    chk("one_rv_drop", i32.result_valid, 0);
    chk("one_hold", i32.result, 200);

    beat(-10, 20, 1, 0);
    chk("fwd_a", i32.a_out, -10);
    chk("fwd_b", i32.b_out, 20);
    chk("fwd_v", i32.out_valid, 1);
    idle(2);
    chk("gap_v", i32.out_valid, 0);
    chk("gap_rv", i32.result_valid, 0);
    beat(-5, -4, 0, 0);
    idle(2);
    beat(3, 3, 0, 0);
    idle(2);
    chk("gap_hold", i32.result, 200);
    beat(2, 3, 0, 1);
    chk("gap_result", i32.result, -165);
    chk("gap_rv_hi", i32.result_valid, 1);

    beat(127, 127, 1, 0);
    beat(127, 127, 0, 0);
    beat(127, 127, 0, 1);
    chk("sat_pos", i16s.result, 32767);
    chk("sat_pos_ovf", i16s.overflow, 1);
    chk("wrap_pos", i16w.result, -17149);
    chk("wrap_pos_ovf", i16w.overflow, 1);
    chk("wide_pos", i32.result, 48387);
    chk("wide_pos_ovf", i32.overflow, 0);
    beat(-128, 127, 1, 0);
    beat(-128, 127, 0, 0);
    beat(-128, 127, 0, 1);
    chk("sat_neg", i16s.result, -32768);
    chk("sat_neg_ovf", i16s.overflow, 1);
    chk("wrap_neg", i16w.result, 16768);
    chk("wrap_neg_ovf", i16w.overflow, 1);
    idle(1);

    beat(5, 10, 1, 0);
    beat(4, 5, 1, 1);
    chk("restart", i32.result, 20);
    chk("restart_ovf", i16s.overflow, 0);
    idle(1);

    drive(0, 0, -3, 0, 0, 1, 1, 0);
    step();
    drive(1, 7, 0, 0, 0, 1, 0, 100);
    step();
    chk("ws_psum", i32.psum_out, 79);
    chk("ws_rv", i32.result_valid, 0);
    drive(0, 9, 0, 0, 0, 1, 0, 500);
    step();
    chk("ws_hold", i32.psum_out, 79);
    drive(1, 1, 2, 0, 0, 1, 1, 0);
    step();
    chk("ws_oldw", i32.psum_out, -3);
    drive(1, 1, 0, 0, 0, 1, 0, 0);
    step();
    chk("ws_neww", i32.psum_out, 2);
    chk("ws_result", i32.result, 20);
    idle(1);

    beat(3, 3, 1, 0);
    beat(4, 4, 0, 0);
    drive(1, 9, 9, 0, 1, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_res", i32.result, 0);
    chk("mid_rst_psum", i32.psum_out, 0);
    chk("mid_rst_rv", i32.result_valid, 0);
    chk("mid_rst_a", i32.a_out, 0);
    rst = 1'b1;
    beat(6, 7, 0, 1);
    chk("post_rst", i32.result, 42);
    chk("post_rst_rv", i32.result_valid, 1);
    idle(1);

    for (int fr = 0; fr < 60; fr++) begin
      n = $urandom_range(1, 5);
      q = {};
      for (int k = 0; k < n; k++) begin
        ra = ($urandom_range(0, 3) == 0) ? -8'sd128 : 8'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? 8'sd127 : 8'($urandom);
        q.push_back(longint'(ra) * longint'(rb));
        beat(ra, rb, k == 0, k == n - 1);
        chk("rnd_fwd", i32.a_out, ra);
        if (k < n - 1) idle($urandom_range(0, 2));
      end
      e32  = fold(q, 32, 1, o32);
      e16s = fold(q, 16, 1, o16s);
      e16w = fold(q, 16, 0, o16w);
      chk("rnd_rv", i32.result_valid, 1);
      chk("rnd_r32", i32.result, e32);
      chk("rnd_o32", i32.overflow, o32);
      chk("rnd_r16s", i16s.result, e16s);
      chk("rnd_o16s", i16s.overflow, o16s);
      chk("rnd_r16w", i16w.result, e16w);
      chk("rnd_o16w", i16w.overflow, o16w);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errs);
    $finish;
  end

endmodule
